// File: rtl/ibex_rollback_pkg.sv
// ibex_rollback_pkg
// Shared types and widths for the register-file checkpoint/rollback controller.
//   rb_state_e  : sequencer states (run, take checkpoint, flush, restore, fatal)
//   RbRetCntW   : width of the retired-instruction counter
//   RbRetryCntW : width of the consecutive-restore counter
package ibex_rollback_pkg;

    localparam int RbRetCntW   = 8;
    localparam int RbRetryCntW = 4;

    typedef enum logic [2:0] {
        RB_RUN     = 3'd0,
        RB_BACKUP  = 3'd1,
        RB_FLUSH   = 3'd2,
        RB_RESTORE = 3'd3,
        RB_FATAL   = 3'd4
    } rb_state_e;

endpackage

// File: rtl/ibex_rollback_if.sv
// ibex_rollback_if
// Bundles the pipeline-facing signals of the rollback controller.
//   slave  : the rollback controller (consumes pipeline status, drives strobes)
//   master : the pipeline / environment side
// Pipeline status : enable_i, instr_retire_i, next_pc_i, wb_busy_i,
//                   mismatch_i, flush_ack_i
// Controller out  : backup_o, restore_o, flush_req_o, restore_pc_o,
//                   restore_pc_valid_o, fatal_o
interface ibex_rollback_if;

    logic        enable_i;
    logic        instr_retire_i;
    logic [31:0] next_pc_i;
    logic        wb_busy_i;
    logic        mismatch_i;
    logic        flush_ack_i;

    logic        backup_o;
    logic        restore_o;
    logic        flush_req_o;
    logic [31:0] restore_pc_o;
    logic        restore_pc_valid_o;
    logic        fatal_o;

    modport slave (
        input  enable_i, instr_retire_i, next_pc_i, wb_busy_i, mismatch_i, flush_ack_i,
        output backup_o, restore_o, flush_req_o, restore_pc_o, restore_pc_valid_o, fatal_o
    );

    modport master (
        output enable_i, instr_retire_i, next_pc_i, wb_busy_i, mismatch_i, flush_ack_i,
        input  backup_o, restore_o, flush_req_o, restore_pc_o, restore_pc_valid_o, fatal_o
    );

endinterface

// File: rtl/ibex_rollback_ctrl.sv
// ibex_rollback_ctrl
// Checkpoint/rollback sequencer for the flip-flop register file shadow copy.
// A checkpoint (backup strobe) is taken after Interval retired instructions
// when no register-file write is outstanding. A lockstep mismatch flushes the
// pipeline, then restores the shadow and redirects fetch to the checkpoint PC.
// MaxRetries restores without an intervening checkpoint escalate to a sticky
// fatal state, left only through reset.
//
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   rb            : ibex_rollback_if.slave (pipeline status in, strobes out)
//   backup_cnt_o, restore_cnt_o : saturating strobe counters, only present
//                   when IBEX_ROLLBACK_PERF_CNT_EN is defined
//
// Optional feature macro: IBEX_ROLLBACK_PERF_CNT_EN
module ibex_rollback_ctrl
    import ibex_rollback_pkg::*;
#(
    parameter int unsigned Interval   = 32,
    parameter int unsigned MaxRetries = 3,
    parameter logic [31:0] BootAddr   = 32'h0000_0080
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    ibex_rollback_if.slave rb
`ifdef IBEX_ROLLBACK_PERF_CNT_EN
    ,
    output logic [15:0]   backup_cnt_o,
    output logic [15:0]   restore_cnt_o
`endif
);

    localparam logic [RbRetCntW-1:0]   IntervalCnt = RbRetCntW'(Interval);
    localparam logic [RbRetryCntW-1:0] RetryLimit  = RbRetryCntW'(MaxRetries);

    rb_state_e               state_q, state_d;
    logic [RbRetCntW-1:0]    ret_cnt_q, ret_cnt_d;
    logic [RbRetryCntW-1:0]  retry_cnt_q, retry_cnt_d;
    logic [31:0]             ckpt_pc_q, ckpt_pc_d;

    always_comb begin
        state_d     = state_q;
        ret_cnt_d   = ret_cnt_q;
        retry_cnt_d = retry_cnt_q;
        ckpt_pc_d   = ckpt_pc_q;

        unique case (state_q)
            RB_RUN: begin
                if (!rb.enable_i) begin
                    // Disabled: no progress tracking and mismatches are ignored.
                    ret_cnt_d = '0;
                end else begin
                    if (rb.instr_retire_i && (ret_cnt_q != IntervalCnt)) begin
                        ret_cnt_d = ret_cnt_q + 1'b1;
                    end
                    if (rb.mismatch_i) begin
                        state_d = RB_FLUSH;
                    end else if ((ret_cnt_q == IntervalCnt) && !rb.wb_busy_i) begin
                        state_d = RB_BACKUP;
                    end
                end
            end
            RB_BACKUP: begin
                // A mismatch here means the state about to be saved may be
                // corrupt, so the previous checkpoint is kept.
                if (rb.mismatch_i) begin
                    state_d = RB_FLUSH;
                end else begin
                    ckpt_pc_d   = rb.next_pc_i;
                    ret_cnt_d   = '0;
                    retry_cnt_d = '0;
                    state_d     = RB_RUN;
                end
            end
            RB_FLUSH: begin
                if (rb.flush_ack_i) begin
                    state_d = (retry_cnt_q == RetryLimit) ? RB_FATAL : RB_RESTORE;
                end
            end
            RB_RESTORE: begin
                retry_cnt_d = retry_cnt_q + 1'b1;
                ret_cnt_d   = '0;
                state_d     = RB_RUN;
            end
            RB_FATAL: begin
                state_d = RB_FATAL;
            end
            default: begin
                state_d = RB_RUN;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= RB_RUN;
            ret_cnt_q   <= '0;
            retry_cnt_q <= '0;
            ckpt_pc_q   <= BootAddr;
        end else begin
            state_q     <= state_d;
            ret_cnt_q   <= ret_cnt_d;
            retry_cnt_q <= retry_cnt_d;
            ckpt_pc_q   <= ckpt_pc_d;
        end
    end

    logic backup_strobe;
    logic restore_strobe;

    assign backup_strobe  = (state_q == RB_BACKUP) && !rb.mismatch_i;
    assign restore_strobe = (state_q == RB_RESTORE);

    assign rb.backup_o           = backup_strobe;
    assign rb.restore_o          = restore_strobe;
    assign rb.restore_pc_valid_o = restore_strobe;
    assign rb.flush_req_o        = (state_q == RB_FLUSH) || (state_q == RB_FATAL);
    assign rb.fatal_o            = (state_q == RB_FATAL);
    assign rb.restore_pc_o       = ckpt_pc_q;

`ifdef IBEX_ROLLBACK_PERF_CNT_EN
    logic [15:0] backup_cnt_q;
    logic [15:0] restore_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            backup_cnt_q  <= '0;
            restore_cnt_q <= '0;
        end else begin
            if (backup_strobe && (backup_cnt_q != 16'hFFFF)) begin
                backup_cnt_q <= backup_cnt_q + 16'd1;
            end
            if (restore_strobe && (restore_cnt_q != 16'hFFFF)) begin
                restore_cnt_q <= restore_cnt_q + 16'd1;
            end
        end
    end

    assign backup_cnt_o  = backup_cnt_q;
    assign restore_cnt_o = restore_cnt_q;
`endif

endmodule

// File: tb/tb_ibex_rollback_ctrl.sv
// tb_ibex_rollback_ctrl
// Directed bench for ibex_rollback_ctrl with Interval = 4, MaxRetries = 3.
// Inputs change on the falling edge; outputs are checked 1 time unit later.
// Output flags are packed as {backup, restore, flush_req, restore_pc_valid, fatal}.
module tb_ibex_rollback_ctrl;

    logic clk_i;
    logic rst_ni;

    ibex_rollback_if rb_if();

`ifdef IBEX_ROLLBACK_PERF_CNT_EN
    logic [15:0] backup_cnt;
    logic [15:0] restore_cnt;
`endif

    ibex_rollback_ctrl #(
        .Interval   (4),
        .MaxRetries (3),
        .BootAddr   (32'h0000_0080)
    ) dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .rb     (rb_if.slave)
`ifdef IBEX_ROLLBACK_PERF_CNT_EN
        ,
        .backup_cnt_o  (backup_cnt),
        .restore_cnt_o (restore_cnt)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int n_assert = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    task automatic exp_o(input string tag, input logic [4:0] flags, input logic [31:0] pc);
        logic [36:0] obs;
        obs = {rb_if.backup_o, rb_if.restore_o, rb_if.flush_req_o,
               rb_if.restore_pc_valid_o, rb_if.fatal_o, rb_if.restore_pc_o};
        chk(tag, 64'(obs), 64'({flags, pc}));
    endtask

    task automatic drv(input logic en, input logic ret, input logic [31:0] pc,
                       input logic busy, input logic mm, input logic ack);
        @(negedge clk_i);
        rb_if.enable_i       = en;
        rb_if.instr_retire_i = ret;
        rb_if.next_pc_i      = pc;
        rb_if.wb_busy_i      = busy;
        rb_if.mismatch_i     = mm;
        rb_if.flush_ack_i    = ack;
        #1;
    endtask

    localparam logic [4:0] F_NONE   = 5'b00000;
    localparam logic [4:0] F_BACKUP = 5'b10000;
    localparam logic [4:0] F_FLUSH  = 5'b00100;
    localparam logic [4:0] F_RESTOR = 5'b01010;
    localparam logic [4:0] F_FATAL  = 5'b00101;

    initial begin
        rst_ni               = 1'b0;
        rb_if.enable_i       = 1'b0;
        rb_if.instr_retire_i = 1'b0;
        rb_if.next_pc_i      = '0;
        rb_if.wb_busy_i      = 1'b0;
        rb_if.mismatch_i     = 1'b0;
        rb_if.flush_ack_i    = 1'b0;
        repeat (2) @(negedge clk_i);
        #1;
        exp_o("reset", F_NONE, 32'h80);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Mismatch before any checkpoint rolls back to the boot address.
        drv(1, 0, 32'h0, 0, 1, 0); exp_o("t0_mm", F_NONE, 32'h80);
        drv(1, 0, 32'h0, 0, 0, 1); exp_o("t0_flush", F_FLUSH, 32'h80);
        drv(1, 0, 32'h0, 0, 0, 0); exp_o("t0_restore", F_RESTOR, 32'h80);
        drv(1, 0, 32'h0, 0, 0, 0); exp_o("t0_run", F_NONE, 32'h80);

        // Four retires reach the interval, then one checkpoint strobe.
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 32'h100, 0, 0, 0); exp_o("t1_ret", F_NONE, 32'h80);
        end
        drv(1, 0, 32'h100, 0, 0, 0); exp_o("t1_wait", F_NONE, 32'h80);
        drv(1, 0, 32'h100, 0, 0, 0); exp_o("t1_backup", F_BACKUP, 32'h80);
        drv(1, 0, 32'h100, 0, 0, 0); exp_o("t1_after", F_NONE, 32'h100);

        // Outstanding write-back holds off the checkpoint.
        for (int i = 0; i < 4; i++) begin
            drv(1, 1, 32'h180, 1, 0, 0); exp_o("t2_ret", F_NONE, 32'h100);
        end
        for (int i = 0; i < 3; i++) begin
            drv(1, 0, 32'h180, 1, 0, 0); exp_o("t2_busy", F_NONE, 32'h100);
        end
        drv(1, 0, 32'h180, 0, 0, 0); exp_o("t2_fall", F_NONE, 32'h100);
        drv(1, 0, 32'h180, 0, 0, 0); exp_o("t2_backup", F_BACKUP, 32'h100);
        drv(1, 0, 32'h180, 0, 0, 0); exp_o("t2_after", F_NONE, 32'h180);

        // Checkpoint at 0x200, then mismatch, 5-cycle flush, restore.
        for (int i = 0; i < 4; i++) drv(1, 1, 32'h200, 0, 0, 0);
        drv(1, 0, 32'h200, 0, 0, 0); exp_o("t3_wait", F_NONE, 32'h180);
        drv(1, 0, 32'h200, 0, 0, 0); exp_o("t3_backup", F_BACKUP, 32'h180);
        drv(1, 0, 32'h200, 0, 1, 0); exp_o("t3_mm", F_NONE, 32'h200);
        for (int i = 0; i < 4; i++) begin
            drv(1, 0, 32'h200, 0, 0, 0); exp_o("t3_flush", F_FLUSH, 32'h200);
        end
        drv(1, 0, 32'h200, 0, 0, 1); exp_o("t3_ack", F_FLUSH, 32'h200);
        drv(1, 0, 32'h200, 0, 0, 0); exp_o("t3_restore", F_RESTOR, 32'h200);
        drv(1, 0, 32'h200, 0, 0, 0); exp_o("t3_run", F_NONE, 32'h200);

        // Mismatch during the checkpoint cycle suppresses the backup.
        for (int i = 0; i < 4; i++) drv(1, 1, 32'h300, 0, 0, 0);
        drv(1, 0, 32'h300, 0, 0, 0); exp_o("t4_wait", F_NONE, 32'h200);
        drv(1, 0, 32'h300, 0, 1, 0); exp_o("t4_bk_mm", F_NONE, 32'h200);
        drv(1, 0, 32'h300, 0, 0, 1); exp_o("t4_flush", F_FLUSH, 32'h200);
        drv(1, 0, 32'h300, 0, 0, 0); exp_o("t4_restore", F_RESTOR, 32'h200);
        drv(1, 0, 32'h300, 0, 0, 0); exp_o("t4_run", F_NONE, 32'h200);

        // Fresh checkpoint clears the retry count.
        for (int i = 0; i < 4; i++) drv(1, 1, 32'h400, 0, 0, 0);
        drv(1, 0, 32'h400, 0, 0, 0);
        drv(1, 0, 32'h400, 0, 0, 0); exp_o("t5_backup", F_BACKUP, 32'h200);

        // Three restores, then the fourth round escalates to fatal.
        for (int r = 0; r < 3; r++) begin
            drv(1, 0, 32'h400, 0, 1, 0); exp_o("t5_mm", F_NONE, 32'h400);
            drv(1, 0, 32'h400, 0, 0, 1); exp_o("t5_flush", F_FLUSH, 32'h400);
            drv(1, 0, 32'h400, 0, 0, 0); exp_o("t5_restore", F_RESTOR, 32'h400);
        end
        drv(1, 0, 32'h400, 0, 1, 0); exp_o("t5_mm4", F_NONE, 32'h400);
        drv(1, 0, 32'h400, 0, 0, 1); exp_o("t5_flush4", F_FLUSH, 32'h400);
        drv(1, 1, 32'h400, 0, 1, 0); exp_o("t5_fatal", F_FATAL, 32'h400);
        for (int i = 0; i < 6; i++) begin
            drv(1, 1, 32'h480, 0, i[0], i[1]); exp_o("t5_sticky", F_FATAL, 32'h400);
        end

        // Asynchronous reset clears fatal immediately.
        @(negedge clk_i);
        rst_ni = 1'b0;
        rb_if.enable_i = 1'b0;
        #1;
        exp_o("t5_reset", F_NONE, 32'h80);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Disabled: retires and mismatches have no effect.
        for (int i = 0; i < 100; i++) begin
            drv(0, 1, 32'h500, 0, (i % 7) == 3, (i % 11) == 5);
            exp_o("t6_disabled", F_NONE, 32'h80);
        end
        drv(1, 0, 32'h500, 0, 0, 0); exp_o("t6_en1", F_NONE, 32'h80);
        drv(1, 0, 32'h500, 0, 0, 0); exp_o("t6_en2", F_NONE, 32'h80);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
